// File: rtl/flag_pkg.sv
// Shared flag-stage definitions: flag bit positions, source-code geometry and named source codes.
package flag_pkg;

  localparam int unsigned NUM_FLAGS = 8;
  localparam int unsigned NUM_SRC   = 48;
  localparam int unsigned SRC_W     = 6;

  // Z80 F register bit order
  localparam int unsigned FLAG_S = 7;
  localparam int unsigned FLAG_Z = 6;
  localparam int unsigned FLAG_Y = 5;
  localparam int unsigned FLAG_H = 4;
  localparam int unsigned FLAG_X = 3;
  localparam int unsigned FLAG_P = 2;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_C = 0;

  typedef logic [SRC_W-1:0] flag_src_t;

  localparam flag_src_t SRC_IS8BITEQUAL = flag_src_t'(19);
  localparam flag_src_t SRC_CY4         = flag_src_t'(21);
  localparam flag_src_t SRC_RESULTLOW0  = flag_src_t'(24);
  localparam flag_src_t SRC_RESULT0     = flag_src_t'(34);
  localparam flag_src_t SRC_ALU0        = flag_src_t'(40);
  localparam flag_src_t SRC_ALU7        = flag_src_t'(47);

endpackage

// File: rtl/flag_pipeline_register_decoder.sv
// Per-flag source decoder: SRC_W-bit code to active-low one-hot select; out-of-range codes select nothing.
module flag_src_decoder
  import flag_pkg::*;
#(
  parameter int unsigned NUM_SRC = flag_pkg::NUM_SRC,
  parameter int unsigned SRC_W   = flag_pkg::SRC_W
) (
  input  logic [SRC_W-1:0]   code,
  input  logic               en,
  output logic [NUM_SRC-1:0] not_select_c
);

  always_comb begin
    not_select_c = '1;
    for (int k = 0; k < int'(NUM_SRC); k++) begin
      if (en && (code == SRC_W'(k))) begin
        not_select_c[k] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/flag_pipeline_register.sv
// Microcode flag-control stage: captures flag fields, gates them with hold, decodes sources
// and owns the shadow flag register F' that is swapped on EX AF,AF'.
module flag_pipeline_register
  import flag_pkg::*;
#(
  parameter int unsigned NUM_SRC = flag_pkg::NUM_SRC,
  parameter int unsigned SRC_W   = flag_pkg::SRC_W
) (
  input  logic                                 Clk,
  input  logic                                 Reset,
  input  logic                                 in_valid,
  input  logic [NUM_FLAGS-1:0]                 in_flag_write,
  input  logic [NUM_FLAGS-1:0][SRC_W-1:0]      in_flag_src,
  input  logic                                 in_ex,
  input  logic                                 in_write,
  input  logic                                 hold,
  input  logic                                 flush,
  input  logic [NUM_FLAGS-1:0]                 F,
  output logic [NUM_FLAGS-1:0]                 PF_Write,
  output logic [NUM_FLAGS-1:0][NUM_SRC-1:0]    notPF_Select,
  output logic                                 PR_Ex,
  output logic                                 notPR_Ex,
  output logic                                 PR_Write,
  output logic                                 notPR_Write,
  output logic [NUM_FLAGS-1:0]                 notShadowF
);

  logic                            valid;
  logic [NUM_FLAGS-1:0]            write;
  logic [NUM_FLAGS-1:0][SRC_W-1:0] src;
  logic                            ex;
  logic                            wr;
  logic [NUM_FLAGS-1:0]            shadow;
  logic                            act;

  // Stage register: reload beats exchange beats per-flag writes; flush beats capture.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      valid <= 1'b0;
      write <= '0;
      src   <= '0;
      ex    <= 1'b0;
      wr    <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (!hold) begin
      valid <= in_valid;
      if (in_valid) begin
        write <= (in_write || in_ex) ? '0 : in_flag_write;
        src   <= in_flag_src;
        ex    <= in_ex && !in_write;
        wr    <= in_write;
      end
    end
  end

  // F' takes F on the same edge the flag registers take ~F', so the swap is atomic.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      shadow <= '0;
    end else if (PR_Ex) begin
      shadow <= F;
    end
  end

  assign act         = valid && !hold;
  assign PF_Write    = act ? write : '0;
  assign PR_Ex       = act && ex;
  assign notPR_Ex    = !PR_Ex;
  assign PR_Write    = act && wr;
  assign notPR_Write = !PR_Write;
  assign notShadowF  = ~shadow;

  for (genvar i = 0; i < int'(NUM_FLAGS); i++) begin : g_dec
    flag_src_decoder #(
      .NUM_SRC (NUM_SRC),
      .SRC_W   (SRC_W)
    ) u_dec (
      .code         (src[i]),
      .en           (PF_Write[i]),
      .not_select_c (notPF_Select[i])
    );
  end

endmodule
